// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data memory.
// Optional starvation guard for fetch is compiled in with `define ARB_STARVE_EN.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("memory_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    state_t r_state;
    state_t w_next;
    logic   w_dreq;
    logic   w_done;
    logic   w_trip;
    logic   w_dcomplete;
    logic   w_icomplete;

    assign w_dreq = dREN | dWEN;
    assign w_done = (ramstate == ACCESS) || (ramstate == ERROR);
    assign iload  = ramload;
    assign dload  = ramload;

`ifdef ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] r_scnt;

    assign w_trip = (r_scnt == LIMIT) && iREN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scnt <= '0;
        end else if (!iREN || w_icomplete) begin
            r_scnt <= '0;
        end else if (w_dcomplete && r_scnt != LIMIT) begin
            r_scnt <= r_scnt + 4'd1;
        end
    end
`else
    assign w_trip = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        w_next      = r_state;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        bus_err     = 1'b0;
        w_dcomplete = 1'b0;
        w_icomplete = 1'b0;

        // Reset suppresses the RAM port and any completion of an aborted access.
        if (!RST) begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && !w_trip) begin
                        w_next = DGRANT;
                    end else if (iREN) begin
                        w_next = IGRANT;
                    end
                end
                DGRANT: begin
                    if (!w_dreq) begin
                        w_next = IDLE;
                    end else begin
                        ramaddr = daddr;
                        if (dWEN) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore;
                        end else begin
                            ramREN = 1'b1;
                        end
                        if (w_done) begin
                            w_dcomplete = 1'b1;
                            dwait       = 1'b0;
                            bus_err     = (ramstate == ERROR);
                            w_next      = IDLE;
                        end
                    end
                end
                IGRANT: begin
                    if (!iREN) begin
                        w_next = IDLE;
                    end else begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        if (w_done) begin
                            w_icomplete = 1'b1;
                            iwait       = 1'b0;
                            bus_err     = (ramstate == ERROR);
                            w_next      = IDLE;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; follows ARB_STARVE_EN like the RTL.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after the inputs were changed.
    task automatic settle();
        #1;
    endtask

    int d_first, i_first, d_second, phase;

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        step(); step();
        settle();
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramWEN", 32'(ramWEN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_iwait", 32'(iwait), 1);
        check("rst_dwait", 32'(dwait), 1);
        check("rst_bus_err", 32'(bus_err), 0);
        RST = 1'b0;

        // Single fetch, ACCESS two cycles after grant.
        step();
        iREN = 1; iaddr = 32'h40; settle();
        check("f_idle_ramREN", 32'(ramREN), 0);
        check("f_idle_iwait", 32'(iwait), 1);
        step(); ramstate = BUSY; settle();
        check("f_g0_ramREN", 32'(ramREN), 1);
        check("f_g0_ramaddr", ramaddr, 32'h40);
        check("f_g0_iwait", 32'(iwait), 1);
        step(); settle();
        check("f_g1_iwait", 32'(iwait), 1);
        check("f_g1_ramaddr", ramaddr, 32'h40);
        step(); ramstate = ACCESS; ramload = 32'h2008_0001; settle();
        check("f_done_iwait", 32'(iwait), 0);
        check("f_done_iload", iload, 32'h2008_0001);
        check("f_done_dwait", 32'(dwait), 1);
        step(); iREN = 0; ramstate = FREE; settle();
        check("f_after_iwait", 32'(iwait), 1);
        check("f_after_ramREN", 32'(ramREN), 0);

        // Collision: data first, one IDLE, then fetch.
        step();
        iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200; ramstate = ACCESS; settle();
        check("c_idle_ramREN", 32'(ramREN), 0);
        step(); settle();
        check("c_d_ramaddr", ramaddr, 32'h200);
        check("c_d_dwait", 32'(dwait), 0);
        check("c_d_iwait", 32'(iwait), 1);
        step(); dREN = 0; settle();
        check("c_gap_ramREN", 32'(ramREN), 0);
        check("c_gap_iwait", 32'(iwait), 1);
        step(); settle();
        check("c_i_ramaddr", ramaddr, 32'h44);
        check("c_i_iwait", 32'(iwait), 0);
        check("c_i_dwait", 32'(dwait), 1);
        step(); iREN = 0; ramstate = FREE;

        // Write wins over read.
        step();
        dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        step(); ramstate = BUSY; settle();
        check("w_busy_ramWEN", 32'(ramWEN), 1);
        check("w_busy_ramREN", 32'(ramREN), 0);
        check("w_busy_ramstore", ramstore, 32'hDEAD_BEEF);
        check("w_busy_ramaddr", ramaddr, 32'h100);
        check("w_busy_dwait", 32'(dwait), 1);
        step(); ramstate = ACCESS; settle();
        check("w_done_dwait", 32'(dwait), 0);
        check("w_done_ramWEN", 32'(ramWEN), 1);
        step(); dREN = 0; dWEN = 0; ramstate = FREE; settle();
        check("w_after_dwait", 32'(dwait), 1);
        check("w_after_ramWEN", 32'(ramWEN), 0);

        // Error on a data grant.
        step();
        dREN = 1; daddr = 32'h300;
        step(); ramstate = ERROR; settle();
        check("e_bus_err", 32'(bus_err), 1);
        check("e_dwait", 32'(dwait), 0);
        step(); settle();
        check("e_next_bus_err", 32'(bus_err), 0);
        check("e_next_ramREN", 32'(ramREN), 0);
        dREN = 0; ramstate = FREE;

        // Withdrawal while granted: no completion, back to IDLE.
        step();
        dREN = 1; daddr = 32'h304;
        step(); ramstate = BUSY; settle();
        check("wd_grant_ramREN", 32'(ramREN), 1);
        dREN = 0; ramstate = ACCESS; settle();
        check("wd_dwait", 32'(dwait), 1);
        step(); ramstate = FREE; settle();
        check("wd_idle_ramREN", 32'(ramREN), 0);

        // Reset during BUSY in IGRANT.
        step();
        iREN = 1; iaddr = 32'h80;
        step(); ramstate = BUSY; settle();
        check("r_grant_ramREN", 32'(ramREN), 1);
        RST = 1; ramstate = ACCESS; settle();
        check("r_abort_iwait", 32'(iwait), 1);
        step(); RST = 0; settle();
        check("r_next_ramREN", 32'(ramREN), 0);
        check("r_next_iwait", 32'(iwait), 1);
        step(); iREN = 0; ramstate = FREE;
        step();

        // Starvation: fetch held, data requests continuous, RAM always ready.
        iREN = 1; dREN = 1; daddr = 32'h400; iaddr = 32'h48; ramstate = ACCESS;
        d_first = 0; i_first = 0; d_second = 0; phase = 0;
        for (int c = 0; c < 24; c++) begin
            step(); settle();
            if (!dwait) begin
                if (phase == 0) d_first++;
                else if (phase == 1) d_second++;
            end
            if (!iwait) begin
                i_first++;
                phase++;
            end
        end
        iREN = 0; dREN = 0; ramstate = FREE;
`ifdef ARB_STARVE_EN
        check("s_data_before_fetch", 32'(d_first), 4);
        check("s_fetch_grants", 32'(i_first), 2);
        check("s_data_after_clear", 32'(d_second), 4);
`else
        check("s_data_grants", 32'(d_first), 12);
        check("s_fetch_grants", 32'(i_first), 0);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequencing controller that shares the single-ported RAM between the instruction-fetch and data-memory request paths of the pipelined MIPS core. It grants one requester at a time, drives the RAM port for that requester, and produces the per-side wait signals that the hazard control unit consumes as `ihit`/`dhit`. Data requests normally win. A bounded-starvation guard keeps instruction fetch from being locked out by back-to-back loads and stores.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch is pending. Legal range 1..15.

Ports:
- `CLK`  in  1  clock. One clock domain.
- `RST`  in  1  reset. Synchronous, active-high.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction word address.
- `iwait`  out  1  instruction request not complete this cycle.
- `iload`  out  32  instruction read data; equals `ramload`.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `dwait`  out  1  data request not complete this cycle.
- `dload`  out  32  data read data; equals `ramload`.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t` from `cpu_types_pkg`: FREE, BUSY, ACCESS, ERROR.
- `bus_err`  out  1  one-cycle pulse when a granted access ends in ERROR.

## Operation
- FSM states: IDLE, DGRANT, IGRANT. State is registered.
- IDLE:
  - No request: stay in IDLE.
  - `dREN|dWEN` set and the starvation guard is not tripped: go to DGRANT.
  - Otherwise, if `iREN` is set: go to IGRANT.
  - RAM outputs are all zero in IDLE.
- DGRANT:
  - Drive `ramaddr`=`daddr`.
  - If `dWEN` is set: `ramWEN`=1, `ramREN`=0, `ramstore`=`dstore`. A write wins when `dREN` and `dWEN` are both set.
  - Else: `ramREN`=1, `ramstore`=0.
- IGRANT: `ramREN`=1, `ramaddr`=`iaddr`, `ramWEN`=0, `ramstore`=0.
- Completion happens in the cycle where, in a grant state, `ramstate` is ACCESS or ERROR.
  - The granted side's wait output goes low for that cycle only.
  - The FSM returns to IDLE on the next edge. The idle cycle lets the requester drop or change its request, so a stale request is never re-granted.
  - ERROR also pulses `bus_err`. The data returned that cycle is undefined.
- Requester withdraws while granted (its enables drop before completion): return to IDLE next edge. No completion is signalled.
- Wait outputs: `iwait`=0 only on an IGRANT completion cycle, otherwise 1. `dwait`=0 only on a DGRANT completion cycle, otherwise 1. Both are 1 in IDLE.
- Starvation counter `scnt`:
  - Width 4 bits.
  - Increments on each DGRANT completion when `iREN` was high in that cycle, saturating at `STARVE_LIMIT`.
  - Clears on an IGRANT completion or any cycle with `iREN`=0.
  - The guard is tripped when `scnt == STARVE_LIMIT` and `iREN`=1. IDLE then chooses IGRANT even if data is pending.
- Requests are not latched. Requesters must hold address, data and enables stable until their wait output drops.

## Timing
- Reset values: state IDLE, `scnt`=0, `ramREN`=0, `ramWEN`=0, `ramaddr`=0, `ramstore`=0, `iwait`=1, `dwait`=1, `bus_err`=0.
- RAM outputs, wait outputs and `bus_err` are combinational from the registered state and the inputs.
- Minimum latency: request asserted in cycle N (IDLE), grant in cycle N+1, completion at earliest in cycle N+1 if the RAM returns ACCESS immediately, back in IDLE at N+2. The next grant is at N+3 at the earliest.
- `ramstate` FREE or BUSY in a grant state: hold the grant and keep the RAM outputs stable.
- `RST` asserted mid-access: next edge returns to IDLE and clears `scnt`. RAM enables are low from that cycle onward. No completion is reported for the aborted access.
- `iload` and `dload` always mirror `ramload`. Validity is defined only on the completion cycle.

## Configuration
- `ARB_STARVE_EN` defined: the starvation counter and guard are compiled in, as described above.
- `ARB_STARVE_EN` undefined:
  - No counter logic is built.
  - Strict data priority: IDLE chooses DGRANT whenever `dREN|dWEN` is set.
  - `STARVE_LIMIT` is ignored.

## Test plan
- Single fetch: `iREN`=1, `iaddr`=0x40, RAM returns ACCESS 2 cycles after grant with `ramload`=0x2008_0001. Required: `ramREN`=1 and `ramaddr`=0x40 during the grant; `iwait`=0 for exactly one cycle; `iload`=0x2008_0001; `dwait` stays 1.
- Collision: `iREN` and `dREN` both rise in the same IDLE cycle. Required: data is granted first, then one IDLE cycle, then the fetch is granted.
- Write priority: `dREN`=`dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF. Required: `ramWEN`=1, `ramREN`=0, `ramstore`=0xDEADBEEF until ACCESS, then `dwait` low for one cycle.
- Starvation (`ARB_STARVE_EN`, `STARVE_LIMIT`=4): hold `iREN`=1 and issue continuous data requests. Required: exactly 4 data completions, then an IGRANT, with `scnt` back at 0 afterwards. With the macro undefined: no IGRANT while data requests persist.
- Error and reset:
  - ERROR on a DGRANT. Required: `bus_err` and `dwait`=0 for one cycle, IDLE next.
  - Separately, `RST` asserted during BUSY in IGRANT. Required: next cycle shows IDLE, `ramREN`=0, `iwait`=1 and no `iwait` low pulse.
